// File: rtl/bram_table_loader.sv
// Write side of the AES T-table/S-box lookup banks: streams table words into
// four replicated banks, full image or one region, with a running XOR checksum.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start/i_full/i_region  load request (full image or one 256-entry region)
//   i_valid/i_data/o_ready   table word stream, ascending address order
//   o_we/o_addr/o_wdata   common write port to all banks (one cycle after accept)
//   o_busy/o_done/o_err   status: load active, last word written, start while busy
//   o_checksum            XOR of all words written in the current/last load
module bram_table_loader #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_full,
    input  logic [1:0]           i_region,
    input  logic                 i_valid,
    input  logic [DATA_W-1:0]    i_data,
    output logic                 o_ready,
    output logic [NUM_BANKS-1:0] o_we,
    output logic [ADDR_W-1:0]    o_addr,
    output logic [DATA_W-1:0]    o_wdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [DATA_W-1:0]    o_checksum
);

    typedef enum logic {
        S_IDLE,
        S_LOAD
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_W-1:0]      r_cnt;
    logic [ADDR_W-1:0]      r_end;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W-1:0]      r_checksum;
    logic [NUM_BANKS-1:0]   r_we;
    logic                   r_done;
    logic                   r_err;

    logic                   w_in_load;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_start;
    logic [ADDR_W-1:0]      w_start_addr;
    logic [ADDR_W-1:0]      w_end_addr;

    assign w_in_load = (r_state == S_LOAD);
    assign w_accept  = w_in_load && i_valid;
    assign w_last    = w_accept && (r_cnt == r_end);
    assign w_start   = (r_state == S_IDLE) && i_start;

    // Region bits sit on top of the byte index.
    assign w_start_addr = i_full ? '0
                        : {i_region, {(ADDR_W-2){1'b0}}};
    assign w_end_addr   = i_full ? '1
                        : {i_region, {(ADDR_W-2){1'b1}}};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_end      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_checksum <= '0;
            r_we       <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we   <= {NUM_BANKS{w_accept}};
            r_done <= w_last;
            r_err  <= i_start && w_in_load;
            // start (IDLE) and accept (LOAD) never coincide
            if (w_start) begin
                r_cnt      <= w_start_addr;
                r_end      <= w_end_addr;
                r_checksum <= '0;
            end
            if (w_accept) begin
                r_addr     <= r_cnt;
                r_wdata    <= i_data;
                r_checksum <= r_checksum ^ i_data;
                r_cnt      <= r_cnt + ADDR_W'(1);
            end
        end
    end

    assign o_ready    = w_in_load;
    assign o_busy     = w_in_load;
    assign o_we       = r_we;
    assign o_addr     = r_addr;
    assign o_wdata    = r_wdata;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_checksum = r_checksum;

endmodule

// File: tb/tb_bram_table_loader.sv
// Self-checking bench for bram_table_loader: table-driven load vectors plus
// hand-written sequences for idle data, reset mid-load and back-to-back loads.
module tb_bram_table_loader;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic        i_full;
    logic [1:0]  i_region;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_ready;
    logic [3:0]  o_we;
    logic [9:0]  o_addr;
    logic [31:0] o_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_checksum;

    int n_chk;
    int n_fail;
    logic [31:0] g_ck;

    bram_table_loader dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_full     (i_full),
        .i_region   (i_region),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_we       (o_we),
        .o_addr     (o_addr),
        .o_wdata    (o_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_checksum (o_checksum)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        full;
        logic [1:0]  region;
        bit          gaps;
        int          err_at;
        logic [31:0] seed;
        logic [9:0]  base;
        int          n;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ready"}, {31'd0, o_ready}, 32'd0);
        chk({nm, "_we"}, {28'd0, o_we}, 32'd0);
        chk({nm, "_addr"}, {22'd0, o_addr}, 32'd0);
        chk({nm, "_wdata"}, o_wdata, 32'd0);
        chk({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, o_done}, 32'd0);
        chk({nm, "_err"}, {31'd0, o_err}, 32'd0);
        chk({nm, "_cksum"}, o_checksum, 32'd0);
    endtask

    // Starts a load and feeds n words; returns in the o_done cycle.
    task automatic run_load(input vec_t v);
        int          k;
        int          cyc;
        bit          vv;
        bit          err_now;
        logic [31:0] kk;
        logic [31:0] d;
        logic [31:0] ck;
        i_start  = 1'b1;
        i_full   = v.full;
        i_region = v.region;
        i_valid  = 1'b0;
        tick();
        i_start = 1'b0;
        chk("start_busy", {31'd0, o_busy}, 32'd1);
        chk("start_ready", {31'd0, o_ready}, 32'd1);
        chk("start_we", {28'd0, o_we}, 32'd0);
        chk("start_cksum", o_checksum, 32'd0);
        k   = 0;
        cyc = 0;
        ck  = '0;
        while (k < v.n && cyc < 4000) begin
            vv = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            kk = k;
            d  = v.seed ^ (kk * 32'h01010101);
            err_now = (v.err_at >= 0) && (k == v.err_at) && vv;
            i_valid = vv;
            i_data  = vv ? d : 32'hA5A5A5A5;
            i_start = err_now;
            i_full  = 1'b1;
            i_region = 2'b00;
            tick();
            i_start = 1'b0;
            cyc++;
            chk("err", {31'd0, o_err}, {31'd0, err_now});
            if (vv) begin
                ck = ck ^ d;
                chk("we", {28'd0, o_we}, 32'hF);
                chk("addr", {22'd0, o_addr}, {22'd0, v.base} + kk);
                chk("wdata", o_wdata, d);
                chk("cksum", o_checksum, ck);
                k++;
                if (k == v.n) begin
                    chk("done", {31'd0, o_done}, 32'd1);
                    chk("end_busy", {31'd0, o_busy}, 32'd0);
                    chk("end_ready", {31'd0, o_ready}, 32'd0);
                end else begin
                    chk("not_done", {31'd0, o_done}, 32'd0);
                    chk("busy", {31'd0, o_busy}, 32'd1);
                end
            end else begin
                chk("gap_we", {28'd0, o_we}, 32'd0);
            end
        end
        if (k < v.n) begin
            n_chk++;
            n_fail++;
            $display("FAIL load_timeout: got %0d words expected %0d", k, v.n);
        end
        i_valid = 1'b0;
        g_ck = ck;
    endtask

    initial begin
        vec_t r;
        n_chk    = 0;
        n_fail   = 0;
        g_ck     = '0;
        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_full   = 1'b0;
        i_region = 2'b00;
        i_valid  = 1'b0;
        i_data   = '0;

        tbl[0] = '{1'b1, 2'b00, 1'b0, -1, 32'h00000000, 10'h000, 1024};
        tbl[1] = '{1'b0, 2'b10, 1'b1, -1, 32'h5A5A0000, 10'h200, 256};
        tbl[2] = '{1'b0, 2'b01, 1'b0, 100, 32'h13579BDF, 10'h100, 256};
        tbl[3] = '{1'b0, 2'b11, 1'b1, 100, 32'hC0FFEE00, 10'h300, 256};
        tbl[4] = '{1'b1, 2'b10, 1'b1, -1, 32'h0BADF00D, 10'h000, 1024};

        repeat (3) tick();
        chk_zero("reset");
        i_reset = 1'b0;
        tick();
        chk_zero("post_reset");

        for (int t = 0; t < 5; t++) begin
            run_load(tbl[t]);
            tick();
            chk("idle_done", {31'd0, o_done}, 32'd0);
            chk("idle_cksum", o_checksum, g_ck);
            tick();
        end

        // Data offered in IDLE is ignored.
        i_valid = 1'b1;
        i_data  = 32'hDEADBEEF;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_ready", {31'd0, o_ready}, 32'd0);
            chk("idle_we", {28'd0, o_we}, 32'd0);
            chk("idle_ck_hold", o_checksum, g_ck);
        end
        i_valid = 1'b0;
        tick();

        // Reset after 50 accepts, then a clean region-0 load.
        i_start  = 1'b1;
        i_full   = 1'b0;
        i_region = 2'b01;
        tick();
        i_start = 1'b0;
        i_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            i_data = 32'h11110000 + c;
            tick();
        end
        chk("pre_rst_addr", {22'd0, o_addr}, 32'h100 + 49);
        i_reset = 1'b1;
        tick();
        chk_zero("mid_rst");
        i_reset = 1'b0;
        i_valid = 1'b0;
        tick();
        chk_zero("mid_rst_idle");
        r = '{1'b0, 2'b00, 1'b1, -1, 32'h77770000, 10'h000, 256};
        run_load(r);

        // Back-to-back: new start issued in the o_done cycle.
        r = '{1'b0, 2'b11, 1'b0, -1, 32'h24680000, 10'h300, 256};
        run_load(r);
        tick();
        chk("b2b_done_clear", {31'd0, o_done}, 32'd0);
        chk("b2b_cksum", o_checksum, g_ck);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
